pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Generates per-latch enable/flush and the PC enable from ihit/dhit, load-use hazard, EX redirect and halt.
//  Gates the EX/MEM dmem request so each load/store reaches the cache exactly once.
//  Sits beside the datapath; all latch enable/flush inputs come from here.
// PARAMETERS
//  REG_W        5   register-select width (regbits_t)
//  CNT_W        32  perf counter width
//  DWAIT_MAX    0   watchdog limit in DWAIT cycles; 0 disables watchdog
// PORTS
//  CLK           in   1      single clock
//  RST           in   1      synchronous reset, active-high
//  ihit          in   1      icache hit for current PC
//  dhit          in   1      dcache completion pulse
//  dmemREN_mem   in   1      EX/MEM dmemREN_out
//  dmemWEN_mem   in   1      EX/MEM dmemWEN_out
//  halt_mem      in   1      EX/MEM halt_out
//  redirect_ex   in   1      taken branch/jump resolved in EX
//  dREN_ex       in   1      ID/EX stage is a load
//  wsel_ex       in   REG_W  ID/EX destination register
//  rs_id, rt_id  in   REG_W  IF/ID source registers
//  pc_en         out  1      PC update enable
//  ifid_en/_flush, idex_en/_flush, exmem_en/_flush, memwb_en/_flush  out 1 each
//  dmem_gate     out  1      AND-ed with dmemREN/WEN toward cache
//  halted        out  1      sticky halt indication
//  wd_err        out  1      sticky watchdog error
//  dstall_cnt    out  CNT_W  cycles stalled on dmem
//  bubble_cnt    out  CNT_W  bubbles inserted (load-use + redirect)
// BEHAVIOUR
//  Reset: state=RUN; all *_en=0, *_flush=1 for one cycle (RST high); halted=0, wd_err=0, counters=0, dmem_gate=1.
//  mem_op = dmemREN_mem | dmemWEN_mem.  advance = cycle in which latches move; combinational from state/inputs.
//  FSM RUN: !mem_op: advance=ihit. mem_op&dhit&ihit: advance, stay RUN. mem_op&dhit&!ihit: ->DDONE.
//          mem_op&!dhit: ->DWAIT.
//  FSM DWAIT: dmem_gate=1; dhit&ihit: advance ->RUN; dhit&!ihit: ->DDONE; else hold.
//  FSM DDONE: dmem_gate=0 (no re-access); ihit: advance ->RUN; else hold.
//  FSM HALT: entered on advance with halt_mem=1 (MEM/WB still captures it that cycle).
//        All enables 0, pc_en=0, halted=1 until RST.
//  Non-advance cycle: all enables 0, all flushes 0 (full freeze).
//  Advance cycle defaults: all enables 1, flushes 0.
//  Load-use: dREN_ex & wsel_ex!=0 & (wsel_ex==rs_id | wsel_ex==rt_id) -> pc_en=0, ifid_en=0,
//    idex_flush=1 (one bubble).
//  Redirect: redirect_ex -> ifid_flush=1, idex_flush=1, pc_en=1 (two bubbles); overrides load-use.
//  Flushes only assert on advance cycles; latch applies flush with priority over capture.
//  Watchdog: DWAIT_MAX>0 and DWAIT lasts DWAIT_MAX consecutive cycles -> wd_err=1 sticky; FSM keeps waiting.
//  RST mid-DWAIT: FSM to RUN next edge; outstanding request abandoned; dmem_gate=1.
//  Latency: zero-cycle combinational enables; state changes on CLK rising edge.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    dstall_cnt +1 each cycle in DWAIT or DDONE;
//    bubble_cnt +1 per load-use bubble, +2 per redirect;
//    both saturate at all-ones.
//  Not defined: counters not built; dstall_cnt, bubble_cnt tied to 0.
// TESTING
//  ihit=1, no mem_op, no hazards for 10 cycles -> all en=1, flushes 0, pc_en=1 each cycle.
//  Load, dhit after 3 cycles with ihit=1 -> 3 freeze cycles (DWAIT), advance on 4th; dstall_cnt=3.
//  Store, dhit at cycle 1, ihit low 2 more cycles -> DDONE 2 cycles, dmem_gate=0 both, then advance.
//  dREN_ex=1, wsel_ex=5, rs_id=5 -> pc_en=0, ifid_en=0, idex_flush=1; same with wsel_ex=0 -> no bubble.
//  Load-use and redirect_ex same cycle -> ifid_flush=idex_flush=1, pc_en=1; bubble_cnt +2.
//  halt_mem=1 on advance -> next cycle halted=1, all en=0; DWAIT_MAX=4, no dhit -> wd_err=1 after 4 cycles.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline latch enable/flush sequencer with dmem gating, halt and watchdog.
// Define PIPE_PERF_CNT_EN to build the saturating dstall/bubble counters (tied to 0 otherwise).
module pipeline_ctrl #(
  parameter int          REG_W     = 5,
  parameter int          CNT_W     = 32,
  parameter int unsigned DWAIT_MAX = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             halt_mem,
  input  logic             redirect_ex,
  input  logic             dREN_ex,
  input  logic [REG_W-1:0] wsel_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             dmem_gate,
  output logic             halted,
  output logic             wd_err,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef enum logic [1:0] {RUN, DWAIT, DDONE, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        wd_err_q, wd_err_d;
  logic        mem_op, advance, load_use;
  assign mem_op   = dmemREN_mem | dmemWEN_mem;
  assign load_use = dREN_ex & (|wsel_ex) & (wsel_ex == rs_id | wsel_ex == rt_id);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end
  // DWAIT and DDONE share the exit rule once dhit has been seen
  always_comb begin
    advance  = (state_q == RUN)   ? (mem_op ? dhit & ihit : ihit) :
               (state_q == DWAIT) ? dhit & ihit :
               (state_q == DDONE) & ihit;
    state_d  = (advance & halt_mem) | (state_q == HALT) ? HALT :
               (state_q == RUN & !mem_op) ? RUN :
               (state_q == DDONE | dhit) ? (ihit ? RUN : DDONE) : DWAIT;
    wd_cnt_d = (state_q == DWAIT & !wd_err_q) ? wd_cnt_q + 32'd1 : '0;
    wd_err_d = wd_err_q | (DWAIT_MAX != 0 && state_q == DWAIT && wd_cnt_q + 32'd1 == DWAIT_MAX);
  end
  always_comb begin
    pc_en       = RST ? 1'b0 : advance & (redirect_ex | !load_use);
    ifid_en     = RST ? 1'b0 : advance & (redirect_ex | !load_use);
    idex_en     = RST ? 1'b0 : advance;
    exmem_en    = RST ? 1'b0 : advance;
    memwb_en    = RST ? 1'b0 : advance;
    ifid_flush  = RST | (advance & redirect_ex);
    idex_flush  = RST | (advance & (redirect_ex | load_use));
    exmem_flush = RST;
    memwb_flush = RST;
    dmem_gate   = RST | (state_q != DDONE);
    halted      = state_q == HALT;
    wd_err      = wd_err_q;
  end
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] dstall_q, dstall_d, bubble_q, bubble_d;
  logic [CNT_W:0]   bubble_sum;
  always_comb begin
    bubble_sum = {1'b0, bubble_q} +
                 {{(CNT_W-1){1'b0}}, advance & redirect_ex, advance & !redirect_ex & load_use};
    bubble_d   = bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
    dstall_d   = dstall_q + {{(CNT_W-1){1'b0}}, (state_q == DWAIT | state_q == DDONE) & ~&dstall_q};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      dstall_q <= '0;
      bubble_q <= '0;
    end else begin
      dstall_q <= dstall_d;
      bubble_q <= bubble_d;
    end
  end
  assign dstall_cnt = dstall_q;
  assign bubble_cnt = bubble_q;
`else
  assign dstall_cnt = '0;
  assign bubble_cnt = '0;
`endif
endmodule
